aes_key_expander: RTL and testbench
===================================

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter KEY_LEN, default 128, key length in bits (128, 192 or 256).
REQ-002 SHALL have parameter WORD_LEN, default 32, word width; any other value is an elaboration error.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port key_in, input, KEY_LEN, cipher key; bits [KEY_LEN-1 -: 32] are w0, the next lower 32 bits are w1, and so on.
REQ-006 SHALL have port key_valid, input, 1, key offer.
REQ-007 SHALL have port key_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port rkey_out, output, 128, round key r as {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-009 SHALL have port rkey_idx, output, 4, round number r of rkey_out.
REQ-010 SHALL have port rkey_valid, output, 1, rkey_out/rkey_idx are valid.
REQ-011 SHALL have port rkey_ready, input, 1, consumer accepts the round key.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last round key is accepted.

Function
REQ-013 SHALL derive Nk = KEY_LEN/32 (4/6/8), Nr = Nk+6 (10/12/14) and total words 4*(Nr+1) (44/52/60); any other KEY_LEN is an elaboration error.
REQ-014 SHALL implement states IDLE, LOAD, SUB, WORD, DRAIN.
- IDLE -> LOAD on key_valid && key_ready.
- LOAD -> SUB or WORD after Nk words have been pushed.
- SUB -> WORD.
- WORD -> SUB, WORD or DRAIN.
- DRAIN -> IDLE.
REQ-015 SHALL capture key_in, set word index i=0 and set Rcon=0x01 on the accept edge.
REQ-016 SHALL, in LOAD, push one key word per cycle (w0 first) into a 4-word round-key assembler, incrementing i.
REQ-017 SHALL compute each word i >= Nk as w[i] = w[i-Nk] ^ temp, where temp = w[i-1] with these modifications:
- i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}.
- Nk == 8 and i mod 8 == 4: temp = SubWord(w[i-1]).
REQ-018 SHALL define RotWord(t) = {t[23:0], t[31:24]}.
REQ-019 SHALL perform SubWord with the existing 1-cycle registered SubWord module, driving its reset with the inverted reset; words that need SubWord spend one SUB cycle before WORD, all other words take one WORD cycle.
REQ-020 SHALL, after each use, update Rcon as xtime(Rcon): shift left by 1, XOR 0x1B if bit 7 was set.
REQ-021 SHALL keep a sliding window of the last Nk words; no full 60-word storage.
REQ-022 SHALL, on the edge a 4th word enters the assembler, register rkey_out, set rkey_idx=r and set rkey_valid=1.
REQ-023 SHALL hold rkey_out/rkey_idx stable while rkey_valid && !rkey_ready.
REQ-024 SHALL allow a push only when !rkey_valid || rkey_ready; otherwise LOAD/SUB/WORD stall with all state frozen (a SUB result is held until consumed).
REQ-025 SHALL, on the same edge, load the next key and keep rkey_valid=1 when rkey_valid && rkey_ready and a 4th word is pushed; otherwise clear rkey_valid after the handshake.
REQ-026 SHALL enter DRAIN after word 4*(Nr+1)-1 is pushed, and wait there for the handshake of rkey_idx=Nr.
REQ-027 SHALL pulse done for one cycle on the edge after the final handshake, return to IDLE and raise key_ready.
REQ-028 SHALL ignore key_valid while not in IDLE.
REQ-029 SHALL, with rkey_ready held 1 and KEY_LEN=128, make round key 0 valid 4 cycles after the accept edge and each later round key valid 5 cycles apart; round 10 is valid at cycle 54.

Reset
REQ-030 SHALL, while reset=1, asynchronously force IDLE, key_ready=1, rkey_valid=0, rkey_out=0, rkey_idx=0, done=0, i=0, Rcon=0x01 and the window to 0.
REQ-031 SHALL, on reset asserted mid-expansion, abort with no further rkey_valid or done until a new key is accepted.

Verification
REQ-032 SHALL cover: KEY_LEN=128, key 2b7e151628aed2a6abf7158809cf4f3c, rkey_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after, 11 keys total.
REQ-033 SHALL cover: KEY_LEN=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> idx0 8e73b0f7da0e6452c810f32b809079e5, idx12 e98ba06f448c773c8ecc720401002202, 13 keys.
REQ-034 SHALL cover: KEY_LEN=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> idx1 1f352c073b6108d72d9810a30914dff4, idx2 9ba354118e6925afa51a8b5f2067fcde, idx14 fe4890d1e6188d0b046df344706c631e.
REQ-035 SHALL cover: random rkey_ready backpressure (including 20-cycle stalls) -> identical key sequence, rkey_out stable during each stall, no index skipped or repeated.
REQ-036 SHALL cover: key_valid pulsed with a different key mid-expansion -> ignored, original sequence intact.
REQ-037 SHALL cover: reset at idx5 -> all outputs 0 and key_ready=1 immediately; a new expansion then matches REQ-032.

Source files
------------

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: key offer / round-key stream bus of the AES key expander.
// Signals: key_in/key_valid/key_ready accept a cipher key; rkey_out/rkey_idx/
// rkey_valid/rkey_ready stream the round keys; done pulses after the last round key.
// master = key source and round-key consumer, slave = expander.
interface aes_key_expander_if #(
   parameter int KEY_LEN = 128
) ();
   logic [KEY_LEN-1:0] key_in;
   logic               key_valid;
   logic               key_ready;
   logic [127:0]       rkey_out;
   logic [3:0]         rkey_idx;
   logic               rkey_valid;
   logic               rkey_ready;
   logic               done;
   modport master (output key_in, key_valid, rkey_ready,
                   input  key_ready, rkey_out, rkey_idx, rkey_valid, done);
   modport slave  (input  key_in, key_valid, rkey_ready,
                   output key_ready, rkey_out, rkey_idx, rkey_valid, done);
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128/192/256 key schedule streaming one 128-bit round key at a time.
// Ports: clk; reset (async, active-high); bus (aes_key_expander_if.slave) carrying
// the key handshake, the round-key stream and the done pulse.
// aes_subword: registered SubWord, one S-box per byte, async active-low reset.
module aes_subword (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   output logic [31:0] dout
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dout <= '0;
      else dout <= {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
endmodule

module aes_key_expander #(
   parameter int KEY_LEN  = 128,
   parameter int WORD_LEN = 32
) (
   input logic               clk,
   input logic               reset,
   aes_key_expander_if.slave bus
);
   localparam int NK    = KEY_LEN / 32;
   localparam int NR    = NK + 6;
   localparam int TOTAL = 4 * (NR + 1);
   if (WORD_LEN != 32) begin : g_bad_word
      $error("aes_key_expander: WORD_LEN must be 32");
   end
   if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key
      $error("aes_key_expander: KEY_LEN must be 128, 192 or 256");
   end
   typedef enum logic [2:0] {IDLE, LOAD, SUB, WORD, DRAIN} state_t;
   state_t             state, state_n;
   // Sliding window of the last NK words, oldest in the top slot.
   logic [KEY_LEN-1:0] win;
   logic [95:0]        asm_q;
   logic [5:0]         i;
   logic [2:0]         k, k_n;
   logic [7:0]         rcon;
   logic [31:0]        last, oldest, sub_in, sub_out, temp, push_w;
   logic               rot, can_push, push, sub_next;
   aes_subword u_sub (.clk(clk), .rst_n(~reset), .din(sub_in), .dout(sub_out));
   // k tracks i mod NK so the 192-bit schedule needs no divider.
   always_comb begin
      last     = win[31:0];
      oldest   = win[KEY_LEN-1 -: 32];
      rot      = k == 3'd0;
      sub_in   = rot ? {last[23:0], last[31:24]} : last;
      temp     = rot ? sub_out ^ {rcon, 24'h0} : (NK == 8 && k == 3'd4) ? sub_out : last;
      push_w   = state == LOAD ? oldest : oldest ^ temp;
      can_push = !bus.rkey_valid || bus.rkey_ready;
      push     = can_push && (state == LOAD || state == WORD);
      k_n      = k == 3'(NK - 1) ? 3'd0 : k + 3'd1;
      sub_next = k_n == 3'd0 || (NK == 8 && k_n == 3'd4);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.key_valid ? LOAD : IDLE;
         LOAD:    state_n = push && k == 3'(NK - 1) ? SUB : LOAD;
         SUB:     state_n = can_push ? WORD : SUB;
         WORD:    state_n = !push ? WORD : i == 6'(TOTAL - 1) ? DRAIN : sub_next ? SUB : WORD;
         DRAIN:   state_n = bus.rkey_valid && bus.rkey_ready ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      bus.key_ready = state == IDLE;
   end
   // LOAD rotates the captured key through the window, so after NK pushes it
   // holds w0..w[NK-1] without a separate key register.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         win            <= '0;
         asm_q          <= '0;
         i              <= '0;
         k              <= '0;
         rcon           <= 8'h01;
         bus.rkey_out   <= '0;
         bus.rkey_idx   <= '0;
         bus.rkey_valid <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         bus.done <= state == DRAIN && bus.rkey_valid && bus.rkey_ready;
         if (state == IDLE && bus.key_valid) begin
            win  <= bus.key_in;
            i    <= '0;
            k    <= '0;
            rcon <= 8'h01;
         end
         if (push) begin
            win   <= {win[KEY_LEN-33:0], push_w};
            asm_q <= {asm_q[63:0], push_w};
            i     <= i + 6'd1;
            k     <= k_n;
            if (state == WORD && rot) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         if (push && i[1:0] == 2'd3) begin
            bus.rkey_out   <= {asm_q, push_w};
            bus.rkey_idx   <= i[5:2];
            bus.rkey_valid <= 1'b1;
         end else if (bus.rkey_ready) bus.rkey_valid <= 1'b0;
      end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed vector bench for the 128/192/256-bit key expanders.
module tb_aes_key_expander;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   aes_key_expander_if #(.KEY_LEN(128)) if0 ();
   aes_key_expander_if #(.KEY_LEN(192)) if1 ();
   aes_key_expander_if #(.KEY_LEN(256)) if2 ();
   aes_key_expander #(.KEY_LEN(128), .WORD_LEN(32)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   aes_key_expander #(.KEY_LEN(192), .WORD_LEN(32)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   aes_key_expander #(.KEY_LEN(256), .WORD_LEN(32)) dut2 (.clk(clk), .reset(reset), .bus(if2));
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   logic [255:0] key [3];
   logic         kv [3], rr [3], kr [3], v [3], d [3];
   logic [3:0]   ix [3];
   logic [127:0] ro [3];
   assign if0.key_in = key[0][255:128];
   assign if1.key_in = key[1][255:64];
   assign if2.key_in = key[2];
   assign if0.key_valid = kv[0];
   assign if1.key_valid = kv[1];
   assign if2.key_valid = kv[2];
   assign if0.rkey_ready = rr[0];
   assign if1.rkey_ready = rr[1];
   assign if2.rkey_ready = rr[2];
   assign kr[0] = if0.key_ready;
   assign kr[1] = if1.key_ready;
   assign kr[2] = if2.key_ready;
   assign v[0] = if0.rkey_valid;
   assign v[1] = if1.rkey_valid;
   assign v[2] = if2.rkey_valid;
   assign d[0] = if0.done;
   assign d[1] = if1.done;
   assign d[2] = if2.done;
   assign ix[0] = if0.rkey_idx;
   assign ix[1] = if1.rkey_idx;
   assign ix[2] = if2.rkey_idx;
   assign ro[0] = if0.rkey_out;
   assign ro[1] = if1.rkey_out;
   assign ro[2] = if2.rkey_out;
   typedef struct {
      int           n;
      int           idx;
      logic [127:0] exp;
   } vec_t;
   vec_t         tab [11];
   int           tests = 0, fails = 0, edges = 0, acc = 0;
   int           nr [3] = '{10, 12, 14};
   int           cnt [3];
   logic         fin [3], pv [3], prr [3], dexp [3];
   logic [127:0] po [3];
   logic [3:0]   pi [3];
   logic [127:0] cap [3][15];
   int           he [3][15];
   always @(posedge clk) edges++;
   // Stream monitor: ordering, stall stability, done timing, capture of every accepted round key.
   always @(negedge clk)
      for (int n = 0; n < 3; n++) begin
         if (d[n] || dexp[n]) begin
            tests++;
            if (d[n] !== dexp[n]) begin
               fails++;
               $display("FAIL done[%0d]: got %b, want %b", n, d[n], dexp[n]);
            end
         end
         if (d[n]) fin[n] = 1'b1;
         dexp[n] = v[n] && rr[n] && ix[n] == 4'(nr[n]);
         if (pv[n] && !prr[n]) begin
            tests++;
            if (!v[n] || ro[n] !== po[n] || ix[n] !== pi[n]) begin
               fails++;
               $display("FAIL hold[%0d]: got v=%b idx=%0d %h, want v=1 idx=%0d %h", n, v[n], ix[n], ro[n], pi[n], po[n]);
            end
         end
         if (v[n] && rr[n]) begin
            tests++;
            if (ix[n] !== 4'(cnt[n])) begin
               fails++;
               $display("FAIL order[%0d]: got idx %0d, want %0d", n, ix[n], cnt[n]);
            end
            cap[n][ix[n]] = ro[n];
            he[n][ix[n]] = edges;
            cnt[n]++;
         end
         pv[n] = v[n];
         prr[n] = rr[n];
         po[n] = ro[n];
         pi[n] = ix[n];
      end
   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask
   task automatic clear(input int n);
      cnt[n] = 0;
      fin[n] = 1'b0;
      pv[n] = 1'b0;
      dexp[n] = 1'b0;
      for (int j = 0; j < 15; j++) begin
         cap[n][j] = '0;
         he[n][j] = 0;
      end
   endtask
   task automatic check_tab(input int n);
      for (int t = 0; t < 11; t++)
         if (tab[t].n == n) chk($sformatf("rkey%0d_idx%0d", n, tab[t].idx), cap[n][tab[t].idx], tab[t].exp);
      chk($sformatf("count%0d", n), 128'(cnt[n]), 128'(nr[n] + 1));
   endtask
   // mode 0: ready held high; 1: random backpressure with a 20-cycle stall; 2: stray key offer mid-run.
   task automatic run(input int n, input int mode);
      int           c, stall;
      logic [255:0] orig;
      orig = key[n];
      clear(n);
      rr[n] = 1'b1;
      kv[n] = 1'b1;
      @(posedge clk);
      #1;
      acc = edges;
      kv[n] = 1'b0;
      chk($sformatf("key_ready_busy%0d", n), 128'(kr[n]), 128'd0);
      c = 0;
      stall = 0;
      while (!fin[n] && c < 4000) begin
         if (mode == 1) begin
            if (stall > 0) begin
               stall--;
               rr[n] = 1'b0;
            end else if (c == 30 || $urandom_range(0, 9) == 0) begin
               stall = 19;
               rr[n] = 1'b0;
            end else rr[n] = 1'($urandom_range(0, 1));
         end
         if (mode == 2 && c == 15) begin
            chk("key_ready_mid", 128'(kr[n]), 128'd0);
            key[n] = ~orig;
            kv[n] = 1'b1;
         end
         if (mode == 2 && c == 18) begin
            key[n] = orig;
            kv[n] = 1'b0;
         end
         @(posedge clk);
         #1;
         c++;
      end
      rr[n] = 1'b1;
      if (!fin[n]) begin
         tests++;
         fails++;
         $display("FAIL timeout%0d: got no done after %0d cycles, want done", n, c);
      end
      chk($sformatf("key_ready_end%0d", n), 128'(kr[n]), 128'd1);
      repeat (3) @(posedge clk);
      #1;
      check_tab(n);
   endtask
   initial begin
      int   c;
      logic bad;
      tab[0]  = '{0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      tab[1]  = '{0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      tab[2]  = '{0, 2,  128'hf2c295f27a96b9435935807a7359f67f};
      tab[3]  = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tab[4]  = '{1, 0,  128'h8e73b0f7da0e6452c810f32b809079e5};
      tab[5]  = '{1, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      tab[6]  = '{1, 12, 128'he98ba06f448c773c8ecc720401002202};
      tab[7]  = '{2, 0,  128'h603deb1015ca71be2b73aef0857d7781};
      tab[8]  = '{2, 1,  128'h1f352c073b6108d72d9810a30914dff4};
      tab[9]  = '{2, 2,  128'h9ba354118e6925afa51a8b5f2067fcde};
      tab[10] = '{2, 14, 128'hfe4890d1e6188d0b046df344706c631e};
      key[0] = K128;
      key[1] = K192;
      key[2] = K256;
      for (int n = 0; n < 3; n++) begin
         kv[n] = 1'b0;
         rr[n] = 1'b1;
         clear(n);
      end
      reset = 1'b1;
      #1;
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("rst_key_ready%0d", n), 128'(kr[n]), 128'd1);
         chk($sformatf("rst_valid%0d", n), 128'(v[n]), 128'd0);
         chk($sformatf("rst_out%0d", n), ro[n], 128'd0);
         chk($sformatf("rst_idx%0d", n), 128'(ix[n]), 128'd0);
         chk($sformatf("rst_done%0d", n), 128'(d[n]), 128'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      run(0, 0);
      chk("lat_idx0", 128'(he[0][0] - acc), 128'd4);
      chk("lat_idx1", 128'(he[0][1] - acc), 128'd9);
      chk("lat_idx10", 128'(he[0][10] - acc), 128'd54);
      run(1, 0);
      run(2, 0);
      run(0, 1);
      run(0, 2);
      clear(0);
      kv[0] = 1'b1;
      @(posedge clk);
      #1;
      kv[0] = 1'b0;
      c = 0;
      while (!(v[0] && ix[0] == 4'd5) && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("reach_idx5", 128'(ix[0]), 128'd5);
      reset = 1'b1;
      #1;
      chk("abort_valid", 128'(v[0]), 128'd0);
      chk("abort_out", ro[0], 128'd0);
      chk("abort_idx", 128'(ix[0]), 128'd0);
      chk("abort_done", 128'(d[0]), 128'd0);
      chk("abort_key_ready", 128'(kr[0]), 128'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear(0);
      bad = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (v[0] || d[0]) bad = 1'b1;
      end
      chk("abort_quiet", 128'(bad), 128'd0);
      run(0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
